// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver.
// Recovers 24-bit pixel words from the serial line, tags each with its index
// within the frame, and flags the latch gap that ends a frame.
module ws2812_rx #(
  parameter int T_MIN      = 2,
  parameter int T_THRESH   = 7,
  parameter int T_HIGH_MAX = 20,
  parameter int T_LATCH    = 600
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        din,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        valid,
  output logic        frame_done,
  output logic        error,
  output logic        busy
);

  localparam int HW = $clog2(T_HIGH_MAX + 2);
  localparam int LW = $clog2(T_LATCH + 1);

  localparam logic [HW-1:0] H_ONE    = HW'(1);
  localparam logic [HW-1:0] H_SAT    = HW'(T_HIGH_MAX + 1);
  localparam logic [HW-1:0] MIN_C    = HW'(T_MIN);
  localparam logic [HW-1:0] THRESH_C = HW'(T_THRESH);
  localparam logic [HW-1:0] HMAX_C   = HW'(T_HIGH_MAX);
  localparam logic [LW-1:0] L_ONE    = LW'(1);
  localparam logic [LW-1:0] LATCH_C  = LW'(T_LATCH);

  typedef enum logic [1:0] {
    WAIT_LATCH,
    IDLE,
    HIGH,
    LOW
  } state_t;

  // High-time counter stops one past the legal maximum so overlong pulses stay detectable.
  function automatic logic [HW-1:0] sat_inc_high(input logic [HW-1:0] v);
    return (v == H_SAT) ? v : v + H_ONE;
  endfunction

  // Low-time counter stops at the latch length.
  function automatic logic [LW-1:0] sat_inc_low(input logic [LW-1:0] v);
    return (v == LATCH_C) ? v : v + L_ONE;
  endfunction

  logic          din_p0;
  logic          din_s;
  logic [LW-1:0] low_cnt;
  logic [LW-1:0] low_nx;
  logic          latch_hit;

  state_t        state;
  logic [HW-1:0] high_cnt;
  logic [HW-1:0] high_nx;
  logic [4:0]    bit_cnt;
  logic [22:0]   shift;
  logic [23:0]   shift_nx;
  logic [7:0]    word_idx;
  logic          bit_val;
  logic          hi_fault;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      din_p0 <= 1'b0;
      din_s  <= 1'b0;
    end else begin
      din_p0 <= din;
      din_s  <= din_p0;
    end
  end

  // Consecutive low cycles; the latch fires on the cycle the run reaches T_LATCH
  assign low_nx    = din_s ? '0 : sat_inc_low(low_cnt);
  assign latch_hit = !din_s && (low_nx == LATCH_C);

  // Running length of the current low period on the synchronized line
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      low_cnt <= '0;
    end else begin
      low_cnt <= low_nx;
    end
  end

  // Decode helpers: the new bit joins the 23 stored bits to form a full word.
  // A fault is either a high pulse growing too long or one ending too soon.
  assign high_nx  = sat_inc_high(high_cnt);
  assign bit_val  = (high_cnt >= THRESH_C);
  assign shift_nx = {shift, bit_val};
  assign hi_fault = din_s ? (high_nx > HMAX_C) : (high_cnt < MIN_C);

  // Protocol state machine with registered pulse and data outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= WAIT_LATCH;
      high_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      word_idx   <= '0;
      rgb_data   <= '0;
      led_num    <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid      <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      case (state)
        WAIT_LATCH: begin
          // Resync point: nothing is decoded until a full latch gap is seen.
          if (latch_hit) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (din_s) begin
            high_cnt <= H_ONE;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (hi_fault) begin
            error    <= 1'b1;
            bit_cnt  <= '0;
            shift    <= '0;
            word_idx <= '0;
            busy     <= 1'b0;
            state    <= WAIT_LATCH;
          end else if (din_s) begin
            high_cnt <= high_nx;
          end else begin
            shift <= shift_nx[22:0];
            busy  <= 1'b1;
            state <= LOW;
            if (bit_cnt == 5'd23) begin
              bit_cnt  <= '0;
              rgb_data <= shift_nx;
              led_num  <= word_idx;
              valid    <= 1'b1;
              if (word_idx != 8'hFF) begin
                word_idx <= word_idx + 8'd1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        LOW: begin
          if (din_s) begin
            high_cnt <= H_ONE;
            state    <= HIGH;
          end else if (latch_hit) begin
            frame_done <= 1'b1;
            error      <= (bit_cnt != 5'd0);
            led_num    <= '0;
            word_idx   <= '0;
            busy       <= 1'b0;
            bit_cnt    <= '0;
            shift      <= '0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= WAIT_LATCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: randomized line traffic compared against
// a symbol-level model of the protocol rules.
module tb_ws2812_rx;

  localparam int T_MIN      = 2;
  localparam int T_THRESH   = 7;
  localparam int T_HIGH_MAX = 20;
  localparam int T_LATCH    = 600;

  typedef struct packed {
    logic        v;
    logic        f;
    logic        e;
    logic [23:0] rgb;
    logic [7:0]  led;
  } ev_t;

  logic        clk;
  logic        reset_n;
  logic        din;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        valid;
  logic        frame_done;
  logic        error;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_fall = 0;
  int   fall1 = 0;

  ev_t  got_q[$];
  ev_t  exp_q[$];
  int   got_cyc[$];

  // model state: synced, bits in word, accumulated word, next index, frame open
  bit   m_sync;
  int   m_bits;
  int   m_acc;
  int   m_idx;
  bit   m_frame;

  ws2812_rx #(
    .T_MIN(T_MIN),
    .T_THRESH(T_THRESH),
    .T_HIGH_MAX(T_HIGH_MAX),
    .T_LATCH(T_LATCH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .din(din),
    .rgb_data(rgb_data),
    .led_num(led_num),
    .valid(valid),
    .frame_done(frame_done),
    .error(error),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // capture every output pulse, sampled away from the active edge
  always @(negedge clk) begin
    if (valid || frame_done || error) begin
      got_q.push_back('{v: valid, f: frame_done, e: error,
                        rgb: valid ? rgb_data : 24'h0,
                        led: valid ? led_num : 8'h0});
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_sync  = 1'b0;
    m_bits  = 0;
    m_acc   = 0;
    m_idx   = 0;
    m_frame = 1'b0;
  endfunction

  // one line symbol: a high pulse of h clocks then a low run of l clocks
  function automatic void model_seg(input int h, input int l);
    ev_t ev;
    if (h > 0 && m_sync) begin
      if (h < T_MIN || h > T_HIGH_MAX) begin
        ev = '0;
        ev.e = 1'b1;
        exp_q.push_back(ev);
        model_reset();
      end else begin
        m_acc = ((m_acc * 2) + ((h >= T_THRESH) ? 1 : 0)) % (1 << 24);
        m_bits++;
        m_frame = 1'b1;
        if (m_bits == 24) begin
          ev = '0;
          ev.v = 1'b1;
          ev.rgb = 24'(m_acc);
          ev.led = 8'(m_idx);
          exp_q.push_back(ev);
          if (m_idx < 255) m_idx++;
          m_bits = 0;
        end
      end
    end
    if (l >= T_LATCH) begin
      if (m_sync && m_frame) begin
        ev = '0;
        ev.f = 1'b1;
        ev.e = (m_bits != 0);
        exp_q.push_back(ev);
      end
      model_reset();
      m_sync = 1'b1;
    end
  endfunction

  // entered and left at 1 time unit after a rising edge
  task automatic seg(input int h, input int l);
    if (h > 0) begin
      din = 1'b1;
      repeat (h) @(posedge clk);
      #1;
    end
    din = 1'b0;
    last_fall = cyc;
    repeat (l) @(posedge clk);
    #1;
    model_seg(h, l);
  endtask

  task automatic send_bit_std(input logic b);
    if (b) seg(10, 5);
    else   seg(4, 11);
  endtask

  task automatic send_word_std(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit_std(w[i]);
  endtask

  task automatic send_word_rand(input int hmin, input int hmax, input int lmin, input int lmax);
    int h;
    int l;
    for (int i = 0; i < 24; i++) begin
      h = int'($urandom_range(hmax, hmin));
      l = int'($urandom_range(lmax, lmin));
      seg(h, l);
    end
  endtask

  task automatic compare_events(input string name);
    int n;
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_ev%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    logic [23:0] w;
    din     = 1'b0;
    reset_n = 1'b0;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", 64'(rgb_data), 64'h0);
    chk("rst_led", 64'(led_num), 64'h0);
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_frame_done", 64'(frame_done), 64'h0);
    chk("rst_error", 64'(error), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    reset_n = 1'b1;
    seg(0, 620);

    // two words in one frame, standard timing
    send_word_std(24'h00FF00);
    fall1 = last_fall;
    chk("s1_busy_mid", 64'(busy), 64'h1);
    send_word_std(24'h123456);
    seg(0, 700);
    chk("s1_latency", 64'(got_cyc.size() > 0 ? got_cyc[0] : -1), 64'(fall1 + 3));
    chk("s1_busy_end", 64'(busy), 64'h0);
    chk("s1_rgb_hold", 64'(rgb_data), 64'h123456);
    chk("s1_led_clear", 64'(led_num), 64'h0);
    compare_events("s1");

    // second frame restarts indexing; random timing word included
    send_word_std(24'hABCDEF);
    send_word_rand(T_MIN, T_HIGH_MAX, 1, 15);
    seg(0, 700);
    compare_events("s2");

    // glitch, then an unsynced frame, then a synced one
    seg(1, 5);
    w = 24'($urandom);
    send_word_std(w);
    seg(0, 620);
    w = 24'($urandom);
    send_word_std(w);
    seg(0, 700);
    compare_events("s3");

    // overlong highs, then a partial word cut by a latch
    seg(25, 620);
    seg(T_HIGH_MAX + 1, 620);
    for (int i = 0; i < 12; i++) send_bit_std(1'($urandom));
    seg(0, 700);
    compare_events("s4");

    // reset mid-word discards the word and forces a resync
    for (int i = 0; i < 8; i++) send_bit_std(1'($urandom));
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    w = 24'($urandom);
    send_word_std(w);
    seg(0, 620);
    send_word_std(24'h5A5A5A);
    seg(0, 700);
    compare_events("s5");

    // index saturation over 258 fast words, then threshold and range edges
    for (int k = 0; k < 258; k++) send_word_rand(T_MIN, T_THRESH, 1, 2);
    for (int i = 0; i < 24; i++) seg((i % 2 == 1) ? T_THRESH : T_THRESH - 1, 3);
    for (int i = 0; i < 24; i++) seg((i < 12) ? T_HIGH_MAX : T_MIN, 3);
    seg(0, 700);
    chk("s6_count_abs", 64'(got_q.size()), 64'd261);
    if (got_q.size() == 261) begin
      chk("s6_led_first", 64'(got_q[0].led), 64'd0);
      chk("s6_led_255", 64'(got_q[255].led), 64'd255);
      chk("s6_led_257", 64'(got_q[257].led), 64'd255);
      chk("s6_thresh_word", 64'(got_q[258].rgb), 64'h555555);
      chk("s6_range_word", 64'(got_q[259].rgb), 64'hFFF000);
    end
    compare_events("s6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
